imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the processor's 512-word instruction memory. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially from word 0. Holds the core in reset until a complete image is written. Sits between the external byte source (UART receiver or testbench) and the write port of the instruction RAM that the fetch path reads.

## Interface

Parameters:
- DEPTH, 512, instruction memory size in words; a header count above DEPTH is rejected.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready at a rising clk edge.
- mem_we  out  1  one-cycle write strobe to the instruction RAM.
- mem_a  out  32  byte address of the word being written (word index × 4, bits [1:0] = 0).
- mem_wd  out  32  instruction word.
- cpu_reset  out  1  held high until the image is loaded.
- done  out  1  image loaded successfully (sticky until reset).
- err  out  1  load rejected (sticky until reset).

## Operation

- Frame: 2 header bytes (word count N, low byte first), then 4·N payload bytes (each word LSB first), then 1 checksum byte when checksum is enabled.
- States:
  - HDR_LO: capture count[7:0] -> HDR_HI.
  - HDR_HI: capture count[15:8].
    - N > DEPTH -> ERROR.
    - N = 0 -> CSUM (or DONE when checksum is disabled).
    - Otherwise -> DATA.
  - DATA: shift bytes into the word register. Byte k of the word goes to bits [8k+7:8k]. After 4 bytes, issue a write and increment the word index. After word N−1 -> CSUM, or DONE when checksum is disabled.
  - CSUM: compare the received byte with the running XOR of all payload bytes. Match -> DONE, mismatch -> ERROR.
  - DONE: in_ready=0, done=1, cpu_reset=0.
  - ERROR: in_ready=0, err=1, cpu_reset=1.
- in_ready = 1 in HDR_LO, HDR_HI, DATA, CSUM; 0 in DONE and ERROR. in_ready is not gated by mem_we.
- The word index is 16 bits wide; mem_a = {14'b0, index, 2'b00}.
- Header bytes are excluded from the checksum. The XOR accumulator resets to 8'h00.
- Stalls (in_valid=0) may occur between any bytes with no timeout; state and partial word are held.

## Timing

- Reset values: in_ready=1 (state HDR_LO), mem_we=0, mem_a=0, mem_wd=0, cpu_reset=1, done=0, err=0. Byte counter, word index and XOR accumulator are all 0.
- Write latency: the edge that accepts byte 3 of a word registers mem_we=1, mem_a and mem_wd. The strobe is visible for exactly the following cycle; mem_a and mem_wd hold until the next write.
- A new byte may be accepted in the same cycle mem_we is high. Back-to-back bytes give one write every 4 cycles.
- cpu_reset falls and done rises on the edge after the final accepting transfer: the checksum byte, or the last payload byte when checksum is disabled. When the last payload byte is the final transfer, that edge also registers the final write, so mem_we is high in the same cycle cpu_reset falls. The word is committed to RAM at the end of that cycle, before the core's first fetch edge.
- Reset asserted mid-frame: on that edge, return to the reset state. The partial word is discarded. RAM contents already written are not cleared.
- done and err are never both 1.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined: the CSUM state and checksum byte are part of the frame; a mismatch goes to ERROR.
- Not defined: no CSUM state and no XOR accumulator. The frame ends after the last payload byte and ERROR is reachable only through N > DEPTH.

## Test plan

- Two-word image, checksum on. Bytes 02 00 00 90 A0 E3 C8 00 A0 E3 58 -> writes (a=0x0, wd=E3A09000) and (a=0x4, wd=E3A000C8), then done=1, cpu_reset=0, err=0.
- Same frame with the checksum byte 59 -> both writes occur, then err=1, cpu_reset=1, done=0, in_ready=0.
- Header 01 02 (N=513), DEPTH=512 -> err=1 after the second byte, no mem_we.
- N=0 (header 00 00, checksum 00) -> done=1, no writes. With the macro undefined, done=1 immediately after the header.
- Random in_valid gaps on the two-word frame -> identical writes and final state; mem_we is exactly one cycle per word.
- Reset after 5 payload bytes of a 2-word frame, then a fresh full frame -> no stray write, and the second frame loads correctly from a=0x0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction RAM.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned DEPTH = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        cpu_reset,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_HDR_LO,
      S_HDR_HI,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   // State entered once the payload is exhausted (or skipped for N=0).
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] word_q, word_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [31:0] mem_wd_q, mem_wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  xor_q, xor_d;
`endif

   logic        accept;
   logic [15:0] hdr_n;
   logic        last_word;

   assign in_ready  = (state_q != S_DONE) && (state_q != S_ERROR);
   assign accept    = in_valid && in_ready;
   assign hdr_n     = {in_data, count_q[7:0]};
   assign last_word = (word_idx_q == (count_q - 16'd1));

   assign mem_we    = mem_we_q;
   assign mem_a     = mem_a_q;
   assign mem_wd    = mem_wd_q;
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERROR);
   assign cpu_reset = (state_q != S_DONE);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      mem_we_d   = 1'b0;
      mem_a_d    = mem_a_q;
      mem_wd_d   = mem_wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d      = xor_q;
`endif

      case (state_q)
         S_HDR_LO: begin
            if (accept) begin
               count_d[7:0] = in_data;
               state_d      = S_HDR_HI;
            end
         end

         S_HDR_HI: begin
            if (accept) begin
               count_d[15:8] = in_data;
               if ({16'd0, hdr_n} > DEPTH)
                  state_d = S_ERROR;
               else if (hdr_n == 16'd0)
                  state_d = S_END;
               else
                  state_d = S_DATA;
            end
         end

         S_DATA: begin
            if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d = xor_q ^ in_data;
`endif
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0: word_d[7:0]   = in_data;
                  2'd1: word_d[15:8]  = in_data;
                  2'd2: word_d[23:16] = in_data;
                  default: begin
                     // Fourth byte completes the word: write it straight from the input.
                     mem_we_d   = 1'b1;
                     mem_wd_d   = {in_data, word_q};
                     mem_a_d    = {14'd0, word_idx_q, 2'b00};
                     word_idx_d = word_idx_q + 16'd1;
                     if (last_word)
                        state_d = S_END;
                  end
               endcase
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept)
               state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
         end
`endif

         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_HDR_LO;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         mem_we_q   <= 1'b0;
         mem_a_q    <= '0;
         mem_wd_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         mem_we_q   <= mem_we_d;
         mem_a_q    <= mem_a_d;
         mem_wd_q   <= mem_wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected RAM writes go into a scoreboard queue checked by a monitor.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        cpu_reset;
   logic        done;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] exp_q[$];
   logic [7:0]  frame[$];
   int          gaps[10] = '{0, 3, 1, 0, 5, 2, 0, 1, 4, 2};

   imem_loader #(.DEPTH(512)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
      .cpu_reset(cpu_reset), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Scoreboard monitor: every write strobe pops one expected (addr, data) pair.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got a=%h wd=%h expected no write", mem_a, mem_wd);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               if ({mem_a, mem_wd} !== e) begin
                  n_fail++;
                  $display("FAIL write: got a=%h wd=%h expected a=%h wd=%h",
                           mem_a, mem_wd, e[63:32], e[31:0]);
               end
            end
         end
      end
   end

   // Called and returns at 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      while (in_ready !== 1'b1 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input bit gappy);
      for (int i = 0; i < frame.size(); i++)
         send_byte(frame[i], gappy ? gaps[i % 10] : 0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      reset    = 1'b0;
   endtask

   task automatic drain_and_check(input string name);
      repeat (3) begin @(posedge clk); #1; end
      check(name, exp_q.size(), 0);
   endtask

   task automatic push_two_word();
      exp_q.push_back({32'h0000_0000, 32'hE3A0_9000});
      exp_q.push_back({32'h0000_0004, 32'hE3A0_00C8});
   endtask

   task automatic load_two_word();
      frame = '{8'h02, 8'h00, 8'h00, 8'h90, 8'hA0, 8'hE3, 8'hC8, 8'h00, 8'hA0, 8'hE3};
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_wd", mem_wd, 0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      reset = 1'b0;

      // Two-word image, back-to-back bytes.
      push_two_word();
      load_two_word();
`ifdef IMEM_LOADER_CHECKSUM_EN
      frame.push_back(8'h58);
`endif
      send_frame(0);
      check("t1_done", done, 1);
      check("t1_cpu_reset", cpu_reset, 0);
      check("t1_err", err, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("t1_final_we_with_release", mem_we, 1);
`endif
      drain_and_check("t1_writes_left");
      check("t1_in_ready", in_ready, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad checksum: writes still happen, frame rejected.
      do_reset();
      push_two_word();
      load_two_word();
      frame.push_back(8'h59);
      send_frame(0);
      check("t2_err", err, 1);
      check("t2_done", done, 0);
      check("t2_cpu_reset", cpu_reset, 1);
      check("t2_in_ready", in_ready, 0);
      drain_and_check("t2_writes_left");
`endif

      // Oversized header N=513.
      do_reset();
      frame = '{8'h01, 8'h02};
      send_frame(0);
      check("t3_err", err, 1);
      check("t3_done", done, 0);
      check("t3_cpu_reset", cpu_reset, 1);
      check("t3_in_ready", in_ready, 0);
      drain_and_check("t3_writes_left");

      // Empty image.
      do_reset();
      frame = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      frame.push_back(8'h00);
`endif
      send_frame(0);
      check("t4_done", done, 1);
      check("t4_cpu_reset", cpu_reset, 0);
      check("t4_err", err, 0);
      drain_and_check("t4_writes_left");

      // Two-word image with in_valid gaps.
      do_reset();
      push_two_word();
      load_two_word();
`ifdef IMEM_LOADER_CHECKSUM_EN
      frame.push_back(8'h58);
`endif
      send_frame(1);
      check("t5_done", done, 1);
      check("t5_cpu_reset", cpu_reset, 0);
      check("t5_err", err, 0);
      drain_and_check("t5_writes_left");

      // Reset after 5 payload bytes, then a fresh one-word frame.
      do_reset();
      exp_q.push_back({32'h0000_0000, 32'hE3A0_9000});
      frame = '{8'h02, 8'h00, 8'h00, 8'h90, 8'hA0, 8'hE3, 8'hC8};
      send_frame(0);
      do_reset();
      check("t6_rst_in_ready", in_ready, 1);
      check("t6_rst_cpu_reset", cpu_reset, 1);
      check("t6_rst_done", done, 0);
      check("t6_rst_mem_a", mem_a, 0);
      exp_q.push_back({32'h0000_0000, 32'h4433_2211});
      frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef IMEM_LOADER_CHECKSUM_EN
      frame.push_back(8'h44);
`endif
      send_frame(0);
      check("t6_done", done, 1);
      check("t6_cpu_reset", cpu_reset, 0);
      check("t6_err", err, 0);
      drain_and_check("t6_writes_left");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
